instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Front end feeding the decode stage: walks the PC, requests words from instruction memory over a
//  req/ack interface, buffers them with their PC in a small queue and presents {instr, pc, opcode}
//  to the Controller/decoder with a valid/ready handshake. Redirects from branch/jump flush it.
// PARAMETERS
//  RESET_PC     32'h0  first fetch address after reset
//  DEPTH        4      queue entries; power of two, >= 2
//  ENDIAN_SWAP  1      1: byte-swap imem_rdata with `ENDIAN_SWP_32 before enqueue; 0: pass through
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  imem_req     out  1   fetch request; held high, imem_addr stable, until imem_ack
//  imem_addr    out  32  word address of request, bits[1:0]=0
//  imem_ack     in   1   transfer completes in a cycle with imem_req && imem_ack
//  imem_rdata   in   32  instruction word, valid only in the ack cycle
//  redirect     in   1   flush and restart fetch at redirect_pc (branch/jump taken)
//  redirect_pc  in   32  new PC; bits[1:0] ignored (forced 0)
//  instr_valid  out  1   queue head valid
//  instr_ready  in   1   decoder accepts head when instr_valid && instr_ready
//  instr        out  32  head instruction (little-endian order)
//  instr_pc     out  32  PC of head instruction
//  opcode       out  7   `OPCODE(instr), wired straight to Controller.opcode
// BEHAVIOUR
//  Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, opcode=0, queue empty,
//   fetch_pc=RESET_PC, FSM=IDLE. All outputs registered or decoded from registered queue state.
//  FSM (registered imem_req = state!=IDLE):
//   IDLE    -> REQ if free slot after this cycle's pop (count - pop < DEPTH) or on redirect.
//   REQ     ack, no redirect: push {data, fetch_pc}; fetch_pc += 4 (wraps 32'hFFFFFFFC -> 0);
//            stay REQ if a slot remains, else IDLE. No ack: hold req/addr.
//   REQ     redirect without ack -> DISCARD; redirect with ack -> data dropped, REQ at redirect_pc.
//   DISCARD req/addr held on stale address until ack; data dropped; then REQ at latest redirect_pc.
//            Further redirects in DISCARD only update fetch_pc.
//  imem_addr = fetch_pc, changes only in cycles where no transfer is pending (never while req un-acked).
//  At most one outstanding request; reservation guarantees the push at ack never overflows.
//  Latency: ack in cycle N -> entry visible (instr_valid=1) in N+1. Single-cycle ack sustains 1 instr/clk.
//  Queue: push and pop in same cycle -> count unchanged; pop on empty impossible (valid gates it);
//   push when count==DEPTH is a design error (assertion).
//  Redirect (highest priority): count, rd/wr pointers -> 0 next cycle, instr_valid=0 next cycle;
//   a head handshake in the redirect cycle still counts as consumed by the decoder; a same-cycle
//   push is discarded. Redirect during reset ignored.
//  Reset mid-operation: asynchronous return to reset state; a pending imem request is abandoned
//   (memory side shares rst_n).
// STRUCTURE
//  types.vh: `OPCODE, `ENDIAN_SWP_32 (existing), add FETCH_IDLE/FETCH_REQ/FETCH_DISCARD localparam
//   encodings (2 bits) and `NOP_INSTR 32'h00000013 for benches.
//  Sub-module fetch_fifo (WIDTH=64, DEPTH): sync FIFO with push/pop/flush, count, full/empty,
//   head data combinational from registered storage. FSM, PC counter, swap logic in the top.
// TESTING
//  Reset, imem_ack tied 1, RESET_PC=0 -> imem_addr 0,4,8,... one per cycle; instr_pc matches; opcode
//   of 32'h00000033 (swapped input 32'h33000000) reads 7'h33.
//  instr_ready=0, ack=1 -> exactly DEPTH pushes, FSM IDLE, imem_req=0; ready=1 one cycle -> one new req.
//  ack delayed 3 cycles -> imem_req/imem_addr stable through all 3; entry appears cycle after ack.
//  redirect to 32'h100 while req to 32'h8 un-acked -> addr stays 8 until ack, data dropped, next
//   req addr 32'h100, first valid instr_pc=32'h100, queue empty in between.
//  redirect with ack same cycle, and with queue full and pop same cycle -> no stale entry, count 0.
//  fetch_pc=32'hFFFFFFFC -> next addr 32'h0; rst_n low mid-WAIT -> all outputs reset values at once.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch_queue_pkg
//  Purpose : Shared types and helpers for the instruction fetch front end:
//            fetch FSM encodings, queue entry layout, opcode extraction and
//            32-bit byte swap.
//  Rev     : 1.0  initial release
// ============================================================================
package instr_fetch_queue_pkg;

    // Fetch FSM encodings (2 bits)
    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    // Canonical NOP (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Queue entry: instruction in the upper half, its PC in the lower half
    localparam int unsigned ENTRY_W = 64;

    // Opcode field of an instruction word
    function automatic logic [6:0] opcode_of(input logic [31:0] i_word);
        return i_word[6:0];
    endfunction

    // Reverse the byte order of a 32-bit word
    function automatic logic [31:0] endian_swap32(input logic [31:0] i_word);
        return {i_word[7:0], i_word[15:8], i_word[23:16], i_word[31:24]};
    endfunction

endpackage : instr_fetch_queue_pkg
`default_nettype wire

// File: rtl/instr_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch_queue_fifo
//  Purpose : Synchronous FIFO with push/pop/flush, occupancy count and
//            full/empty flags. Head data is read combinationally from
//            registered storage.
//  Ports   : clk, rst_n        clock / async active-low reset
//            i_push, i_wdata   enqueue request and data
//            i_pop             dequeue head (ignored when empty)
//            i_flush           empty the queue (wins over push/pop)
//            o_rdata           head entry
//            o_count           occupancy, 0..DEPTH
//            o_full, o_empty   occupancy flags
//  Rev     : 1.0  initial release
// ============================================================================
module instr_fetch_queue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Storage is reset so the head reads a defined value before first write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH_CNT);
    assign o_empty = (r_count == '0);

endmodule : instr_fetch_queue_fifo
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch_queue
//  Purpose : Instruction fetch front end. Walks the PC, issues one request at
//            a time to instruction memory (req/ack), buffers returned words
//            with their PC and presents {instr, pc, opcode} to the decoder
//            through a valid/ready handshake. Redirects flush the queue and
//            restart fetch.
//  Ports   : clk, rst_n              clock / async active-low reset
//            imem_req/addr/ack/rdata memory request interface
//            redirect, redirect_pc   branch/jump restart
//            instr_valid/ready       decoder handshake on queue head
//            instr, instr_pc, opcode head instruction, its PC, opcode field
//  Rev     : 1.0  initial release
// ============================================================================
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          DEPTH       = 4,
    parameter bit          ENDIAN_SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    fetch_state_t  r_state;
    logic [31:0]   r_addr;      // address currently presented / next to fetch
    logic [31:0]   r_redir_pc;  // restart target remembered while discarding

    logic [31:0]        w_rpc;
    logic [31:0]        w_wdata;
    logic [ENTRY_W-1:0] w_head;
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_cnt_after_pop;
    logic [CW-1:0]      w_cnt_next;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_slot_after_pop;
    logic               w_slot_after_push;

    assign w_rpc   = redirect_pc & ~32'h3;
    assign w_wdata = ENDIAN_SWAP ? endian_swap32(imem_rdata) : imem_rdata;

    // Only a clean ack in REQ delivers data; a same-cycle redirect drops it
    assign w_push = (r_state == FETCH_REQ) && imem_ack && !redirect;
    assign w_pop  = !w_empty && instr_ready;

    // A new request is only issued when the slot it will fill is free, so the
    // push on ack can never overflow the queue.
    assign w_cnt_after_pop   = w_count - CW'(w_pop);
    assign w_cnt_next        = w_cnt_after_pop + CW'(w_push);
    assign w_slot_after_pop  = (w_cnt_after_pop < c_DEPTH_CNT);
    assign w_slot_after_push = (w_cnt_next < c_DEPTH_CNT);

    instr_fetch_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata ({w_wdata, r_addr}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH_IDLE;
            r_addr     <= RESET_PC;
            r_redir_pc <= RESET_PC;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        r_addr  <= w_rpc;
                        r_state <= FETCH_REQ;
                    end else if (w_slot_after_pop) begin
                        r_state <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_addr <= w_rpc;
                        end else begin
                            // Request must complete on its stale address first
                            r_redir_pc <= w_rpc;
                            r_state    <= FETCH_DISCARD;
                        end
                    end else if (imem_ack) begin
                        r_addr  <= r_addr + 32'd4;
                        r_state <= w_slot_after_push ? FETCH_REQ : FETCH_IDLE;
                    end
                end
                FETCH_DISCARD: begin
                    if (imem_ack) begin
                        r_addr  <= redirect ? w_rpc : r_redir_pc;
                        r_state <= FETCH_REQ;
                    end else if (redirect) begin
                        r_redir_pc <= w_rpc;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (r_state != FETCH_IDLE);
    assign imem_addr   = r_addr;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? 32'h0 : w_head[63:32];
    assign instr_pc    = w_empty ? 32'h0 : w_head[31:0];
    assign opcode      = opcode_of(instr);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full));

endmodule : instr_fetch_queue
`default_nettype wire
